modular_half_pipe: RTL and testbench

Multi-lane, pipelined modular divide-by-2^k unit for the NTT datapath. Each beat carries LANES coefficients in [0, Q) and a shift count k. Every lane of the beat is returned as x·2^(-k) mod Q, using one conditional modular halving per pipeline stage. The unit sits on the INTT output path and performs the final n^(-1) scaling, or per-layer halving when k=1. It uses a valid/ready handshake in both directions.

---
 rtl/ntt_pkg.sv | 7 +
 rtl/mod_half_lane.sv | 13 +
 rtl/modular_half_pipe.sv | 74 +++++++
 tb/tb_modular_half_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT datapath constants and coefficient type
package ntt_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int Q = 3329;
  localparam int Q_HALF = (Q + 1) / 2;
  typedef logic [DATA_WIDTH-1:0] coeff_t;
endpackage

// File: rtl/mod_half_lane.sv
// mod_half_lane: combinational x*2^-1 mod Q for odd Q, x in [0, Q)
module mod_half_lane #(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int Q = ntt_pkg::Q
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);
  import ntt_pkg::*;
  localparam logic [DATA_WIDTH-1:0] QH = DATA_WIDTH'((Q + 1) / 2);
  // (Q-1)/2 + (Q+1)/2 = Q, so the odd-case sum never overflows DATA_WIDTH
  assign y = {1'b0, x[DATA_WIDTH-1:1]} + (x[0] ? QH : '0);
endmodule

// File: rtl/modular_half_pipe.sv
// modular_half_pipe: LANES-wide x*2^-k mod Q pipeline, MAX_K stages; MODHALF_RANGE_CHECK_EN adds the out_err range flag
module modular_half_pipe #(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int Q = ntt_pkg::Q,
  parameter int LANES = 4,
  parameter int MAX_K = 7,
  parameter int KW = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [KW-1:0]               in_k,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_err
);
  import ntt_pkg::*;
  localparam int W = LANES * DATA_WIDTH;
  logic live, adv;
  logic [MAX_K:0] v;
  logic [W-1:0] d [MAX_K+1];
  logic [W-1:0] hd [MAX_K];
  logic [KW-1:0] k [MAX_K];
  logic [KW-1:0] k_in;
  assign adv = !v[MAX_K] || out_ready;
  // live keeps in_ready low until the first edge after reset release
  assign in_ready = live && adv;
  assign k_in = 32'(in_k) > MAX_K ? KW'(MAX_K) : in_k;
  assign out_valid = v[MAX_K];
  assign out_data = d[MAX_K];
  for (genvar s = 0; s < MAX_K; s++) begin : g_stage
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      mod_half_lane #(.DATA_WIDTH(DATA_WIDTH), .Q(Q)) u_half (
        .x(d[s][l*DATA_WIDTH +: DATA_WIDTH]),
        .y(hd[s][l*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
      v <= '0;
      for (int s = 0; s <= MAX_K; s++) d[s] <= '0;
      for (int s = 0; s < MAX_K; s++) k[s] <= '0;
    end else begin
      live <= 1'b1;
      if (adv) begin
        v <= {v[MAX_K-1:0], in_valid && in_ready};
        d[0] <= in_data;
        k[0] <= k_in;
        for (int s = 0; s < MAX_K; s++) d[s+1] <= k[s] != '0 ? hd[s] : d[s];
        for (int s = 0; s < MAX_K - 1; s++) k[s+1] <= k[s] != '0 ? k[s] - 1'b1 : k[s];
      end
    end
  end
`ifdef MODHALF_RANGE_CHECK_EN
  logic [MAX_K:0] e;
  logic err_in;
  always_comb begin
    err_in = 1'b0;
    for (int l = 0; l < LANES; l++) err_in = err_in | (32'(in_data[l*DATA_WIDTH +: DATA_WIDTH]) >= Q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= '0;
    else if (adv) e <= {e[MAX_K-1:0], err_in && in_valid && in_ready};
  end
  assign out_err = e[MAX_K];
`else
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_modular_half_pipe.sv
// tb_modular_half_pipe: randomized and directed check of modular_half_pipe against a modular-arithmetic model
module tb_modular_half_pipe;
  localparam int DW = 12;
  localparam int Q = 3329;
  localparam int QH = (Q + 1) / 2;
  localparam int LANES = 4;
  localparam int MAX_K = 7;
  localparam int KW = 3;
  localparam int W = LANES * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic [KW-1:0] in_k = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic out_err;

  modular_half_pipe #(.DATA_WIDTH(DW), .Q(Q), .LANES(LANES), .MAX_K(MAX_K), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_k(in_k), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane [LANES];
    int k;
    bit bad;
    int stamp;
  } beat_t;

  beat_t q [$];
  int checks = 0;
  int failures = 0;
  int advcnt = 0;
  bit live_m = 1'b0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic prev_err;
  int mode = 0;
  int pidx = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // x * (2^-1)^k mod Q, computed as a modular power rather than repeated halving
  function automatic int model(input int x, input int k);
    longint m = 1;
    for (int i = 0; i < k; i++) m = (m * QH) % Q;
    return int'((longint'(x) * m) % Q);
  endfunction

  always @(negedge clk) begin
    bit exp_ov, exp_rdy;
    if (!rst_n) begin
      q.delete();
      live_m = 1'b0;
      prev_stall = 1'b0;
      chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
      chk(in_ready == 1'b0, "rst_in_ready", 64'(in_ready), 64'd0);
      chk(out_data == '0, "rst_out_data", 64'(out_data), 64'd0);
      chk(out_err == 1'b0, "rst_out_err", 64'(out_err), 64'd0);
    end else begin
      exp_ov = q.size() > 0 && (advcnt - q[0].stamp == MAX_K + 1);
      chk(out_valid == exp_ov, "out_valid", 64'(out_valid), 64'(exp_ov));
      exp_rdy = live_m && (!exp_ov || out_ready);
      chk(in_ready == exp_rdy, "in_ready", 64'(in_ready), 64'(exp_rdy));
      if (prev_stall) begin
        chk(out_data == prev_data, "stall_data", 64'(out_data), 64'(prev_data));
        chk(out_err == prev_err, "stall_err", 64'(out_err), 64'(prev_err));
      end
      if (exp_ov && out_ready) begin
        beat_t b;
        logic [W-1:0] e;
        bit eerr;
        b = q.pop_front();
        for (int l = 0; l < LANES; l++) e[l*DW +: DW] = DW'(model(b.lane[l], b.k));
`ifdef MODHALF_RANGE_CHECK_EN
        eerr = b.bad;
`else
        eerr = 1'b0;
`endif
        if (!b.bad) chk(out_data == e, "out_data", 64'(out_data), 64'(e));
        chk(out_err == eerr, "out_err", 64'(out_err), 64'(eerr));
      end
      if (in_valid && exp_rdy) begin
        beat_t b;
        b.bad = 1'b0;
        for (int l = 0; l < LANES; l++) begin
          b.lane[l] = int'(in_data[l*DW +: DW]);
          if (b.lane[l] >= Q) b.bad = 1'b1;
        end
        b.k = int'(in_k) > MAX_K ? MAX_K : int'(in_k);
        b.stamp = advcnt;
        q.push_back(b);
      end
      if (!exp_ov || out_ready) advcnt++;
      prev_stall = exp_ov && !out_ready;
      prev_data = out_data;
      prev_err = out_err;
      live_m = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mode == 1) begin
      out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
      pidx++;
    end else if (mode == 2) out_ready = 1'($urandom_range(0, 3) != 0);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int a, input int b, input int c, input int d, input int k);
    bit acc = 1'b0;
    int lanes [LANES];
    lanes = '{a, b, c, d};
    in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = DW'(lanes[l]);
    in_k = KW'(k);
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk(1'b0, "send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    chk(model(1, 1) == 1665, "pin_k1_1", 64'(model(1, 1)), 64'd1665);
    chk(model(2, 1) == 1, "pin_k1_2", 64'(model(2, 1)), 64'd1);
    chk(model(3327, 1) == 3328, "pin_k1_3327", 64'(model(3327, 1)), 64'd3328);
    chk(model(3328, 1) == 1664, "pin_k1_3328", 64'(model(3328, 1)), 64'd1664);
    chk(model(1, 7) == 3303, "pin_k7_1", 64'(model(1, 7)), 64'd3303);
    chk(model(5, 0) == 5, "pin_k0", 64'(model(5, 0)), 64'd5);
    #2 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    send(1, 2, 3327, 3328, 1);
    send(1, 1, 1, 1, 7);
    send(1, 3303 * 128 % Q, 1, 0, 7);
    send(0, 5, 1664, 3328, 0);
    send(3328, 3327, 1, 2, 7);
    step(10);
    mode = 1;
    pidx = 0;
    for (int i = 0; i < 12; i++) send(i * 277, i + 1, Q - 1 - i, i * 3, i % 8);
    step(20);
    mode = 0;
    out_ready = 1'b1;
    send(3329, 1, 2, 3, 1);
    send(4, 5, 6, 7, 2);
    send(8, 9, 3330, 4095, 3);
    send(10, 11, 12, 13, 0);
    step(10);
    mode = 2;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = DW'($urandom_range(0, Q - 1));
      in_k = KW'($urandom_range(0, MAX_K));
      step(1);
    end
    in_valid = 1'b0;
    mode = 0;
    out_ready = 1'b1;
    step(12);
    send(100, 200, 300, 400, 3);
    send(101, 201, 301, 401, 4);
    send(102, 202, 302, 402, 5);
    send(103, 203, 303, 403, 6);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    send(7, 8, 9, 10, 2);
    for (int t = 0; t < 60 && q.size() > 0; t++) step(1);
    chk(q.size() == 0, "drain", 64'(q.size()), 64'd0);
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
